// File: rtl/bootram_bus_bridge.sv
// rtl/bootram_bus_bridge.sv - CPU/loader bus stage driving four byte-lane boot RAM BRAMs
// Loader bytes win arbitration; every access ends in a one-cycle ACK so a held valid is never reissued.
module bootram_bus_bridge #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W+1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W+1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              wr_lock,
  output logic              wr_viol,
  output logic [3:0]        ram_ce,
  output logic [3:0]        ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              ram_oce,
  output logic              ram_reset
);

  typedef enum logic [1:0] {IDLE, WR_DONE, RD_WAIT, ACK} state_t;

  state_t     state;
  logic       serve_ld;
  logic       rd_phase;
  logic [3:0] ld_lane;

  // CPU accesses are word-aligned; the low address bits carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

  assign ld_lane   = 4'b0001 << ld_addr[1:0];
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      serve_ld  <= 1'b0;
      rd_phase  <= 1'b0;
      mem_ready <= 1'b0;
      ld_ready  <= 1'b0;
      mem_rdata <= '0;
      wr_viol   <= 1'b0;
      ram_ce    <= '0;
      ram_wre   <= '0;
      ram_ad    <= '0;
      ram_din   <= '0;
    end else begin
      mem_ready <= 1'b0;
      ld_ready  <= 1'b0;
      ram_ce    <= '0;
      ram_wre   <= '0;
      case (state)
        IDLE: begin
          if (ld_valid) begin
            serve_ld <= 1'b1;
            ram_ce   <= ld_lane;
            ram_wre  <= ld_lane;
            ram_ad   <= ld_addr[ADDR_W+1:2];
            ram_din  <= {4{ld_data}};
            state    <= WR_DONE;
          end else if (mem_valid) begin
            serve_ld <= 1'b0;
            ram_ad   <= mem_addr[ADDR_W+1:2];
            if (|mem_wstrb) begin
              // A locked write still completes with normal timing so the CPU never stalls.
              if (wr_lock) begin
                wr_viol <= 1'b1;
              end else begin
                ram_ce  <= mem_wstrb;
                ram_wre <= mem_wstrb;
                ram_din <= mem_wdata;
              end
              state <= WR_DONE;
            end else begin
              ram_ce   <= 4'hF;
              rd_phase <= 1'b0;
              state    <= RD_WAIT;
            end
          end
        end
        WR_DONE: begin
          if (serve_ld) ld_ready  <= 1'b1;
          else          mem_ready <= 1'b1;
          state <= ACK;
        end
        RD_WAIT: begin
          // First edge here is the RAM sampling the address; data is captured on the second.
          if (rd_phase) begin
            mem_rdata <= ram_dout;
            mem_ready <= 1'b1;
            state     <= ACK;
          end else begin
            rd_phase <= 1'b1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// tb/tb_bootram_bus_bridge.sv - vector-table bench for bootram_bus_bridge with a four-lane RAM model
module tb_bootram_bus_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [12:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [12:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        wr_lock = 1'b0;
  logic        wr_viol;
  logic [3:0]  ram_ce;
  logic [3:0]  ram_wre;
  logic [10:0] ram_ad;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = '0;
  logic        ram_oce;
  logic        ram_reset;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bootram_bus_bridge #(.ADDR_W(11)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_lock(wr_lock), .wr_viol(wr_viol),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_oce(ram_oce), .ram_reset(ram_reset)
  );

  // Four 2Kx8 single-port lanes, bypass read: data appears after the sampling edge.
  logic [7:0] mem [4][2048];
  initial begin
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 2048; a++) mem[l][a] = 8'h00;
  end
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (ram_ce[l]) begin
        if (ram_wre[l]) mem[l][ram_ad] <= ram_din[8*l +: 8];
        else            ram_dout[8*l +: 8] <= mem[l][ram_ad];
      end
    end
  end

  typedef struct {
    logic        is_ld;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        lock;
    logic [3:0]  exp_ce;
    logic [3:0]  exp_wre;
    logic [10:0] exp_ad;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_viol;
  } vec_t;

  function automatic vec_t mk(input logic is_ld, input logic [12:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic lock, input logic [3:0] ce,
                              input logic [3:0] wre, input logic [10:0] ad, input int lat,
                              input logic [31:0] rd, input logic viol);
    vec_t v;
    v.is_ld = is_ld; v.addr = addr; v.wdata = wdata; v.strb = strb; v.lock = lock;
    v.exp_ce = ce; v.exp_wre = wre; v.exp_ad = ad; v.exp_lat = lat;
    v.exp_rdata = rd; v.exp_viol = viol;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, output logic [3:0] ce, output logic [3:0] wre,
                           output logic [10:0] ad, output logic [31:0] din,
                           output logic [3:0] ce_after, output int lat,
                           output logic [31:0] rdata, output logic other_ready);
    ce = 'x; wre = 'x; ad = 'x; din = 'x; ce_after = 'x; rdata = 'x;
    lat = -1;
    other_ready = 1'b0;
    wr_lock = v.lock;
    if (v.is_ld) begin
      ld_valid = 1'b1; ld_addr = v.addr; ld_data = v.wdata[7:0];
    end else begin
      mem_valid = 1'b1; mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.strb;
    end
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin ce = ram_ce; wre = ram_wre; ad = ram_ad; din = ram_din; end
      if (n == 1) ce_after = ram_ce;
      if (v.is_ld ? mem_ready : ld_ready) other_ready = 1'b1;
      if (v.is_ld ? ld_ready : mem_ready) begin
        lat = n; rdata = mem_rdata;
        break;
      end
    end
    ld_valid = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs[14];

  initial begin
    logic [3:0]  ce, wre, ce_after;
    logic [10:0] ad;
    logic [31:0] din, rdata, exp_din;
    logic        other;
    int          lat, t_ld, t_mem;
    logic [3:0]  first_ce;
    logic        both;

    vecs[0]  = mk(0, 13'h010,  32'hDEADBEEF, 4'hF, 0, 4'hF, 4'hF, 11'h004, 1, 32'h0,        0);
    vecs[1]  = mk(0, 13'h010,  32'h0,        4'h0, 0, 4'hF, 4'h0, 11'h004, 2, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 13'h010,  32'h00AA0000, 4'h4, 0, 4'h4, 4'h4, 11'h004, 1, 32'h0,        0);
    vecs[3]  = mk(0, 13'h010,  32'h0,        4'h0, 0, 4'hF, 4'h0, 11'h004, 2, 32'hDEAABEEF, 0);
    vecs[4]  = mk(1, 13'h013,  32'h5A,       4'h0, 0, 4'h8, 4'h8, 11'h004, 1, 32'h0,        0);
    vecs[5]  = mk(0, 13'h010,  32'h0,        4'h0, 0, 4'hF, 4'h0, 11'h004, 2, 32'h5AAABEEF, 0);
    vecs[6]  = mk(1, 13'h1FFF, 32'h33,       4'h0, 0, 4'h8, 4'h8, 11'h7FF, 1, 32'h0,        0);
    vecs[7]  = mk(1, 13'h1FFC, 32'h11,       4'h0, 0, 4'h1, 4'h1, 11'h7FF, 1, 32'h0,        0);
    vecs[8]  = mk(0, 13'h1FFC, 32'h0,        4'h0, 0, 4'hF, 4'h0, 11'h7FF, 2, 32'h33000011, 0);
    vecs[9]  = mk(0, 13'h012,  32'h0,        4'h0, 0, 4'hF, 4'h0, 11'h004, 2, 32'h5AAABEEF, 0);
    vecs[10] = mk(0, 13'h010,  32'h00000000, 4'hF, 1, 4'h0, 4'h0, 11'h004, 1, 32'h0,        1);
    vecs[11] = mk(0, 13'h010,  32'h0,        4'h0, 1, 4'hF, 4'h0, 11'h004, 2, 32'h5AAABEEF, 1);
    vecs[12] = mk(1, 13'h012,  32'hAA,       4'h0, 1, 4'h4, 4'h4, 11'h004, 1, 32'h0,        1);
    vecs[13] = mk(0, 13'h010,  32'h0,        4'h0, 0, 4'hF, 4'h0, 11'h004, 2, 32'h5AAABEEF, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_ld_ready",  {31'b0, ld_ready},  32'h0);
    check("rst_ram_ce",    {28'b0, ram_ce},    32'h0);
    check("rst_ram_wre",   {28'b0, ram_wre},   32'h0);
    check("rst_ram_ad",    {21'b0, ram_ad},    32'h0);
    check("rst_ram_din",   ram_din,            32'h0);
    check("rst_mem_rdata", mem_rdata,          32'h0);
    check("rst_wr_viol",   {31'b0, wr_viol},   32'h0);
    check("ram_oce",       {31'b0, ram_oce},   32'h1);
    check("ram_reset",     {31'b0, ram_reset}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      do_access(vecs[i], ce, wre, ad, din, ce_after, lat, rdata, other);
      check($sformatf("v%0d_ce", i),       {28'b0, ce},       {28'b0, vecs[i].exp_ce});
      check($sformatf("v%0d_wre", i),      {28'b0, wre},      {28'b0, vecs[i].exp_wre});
      check($sformatf("v%0d_ad", i),       {21'b0, ad},       {21'b0, vecs[i].exp_ad});
      check($sformatf("v%0d_ce_drop", i),  {28'b0, ce_after}, 32'h0);
      check($sformatf("v%0d_latency", i),  lat,               vecs[i].exp_lat);
      check($sformatf("v%0d_other_rdy", i), {31'b0, other},   32'h0);
      check($sformatf("v%0d_wr_viol", i),  {31'b0, wr_viol},  {31'b0, vecs[i].exp_viol});
      if (!vecs[i].is_ld && vecs[i].strb == 4'h0)
        check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_wre != 4'h0) begin
        exp_din = vecs[i].is_ld ? {4{vecs[i].wdata[7:0]}} : vecs[i].wdata;
        check($sformatf("v%0d_din", i), din, exp_din);
      end
    end

    // Simultaneous loader write and CPU read: loader first, CPU read 4 cycles after ld_ready.
    wr_lock = 1'b0;
    ld_valid = 1'b1; ld_addr = 13'h011; ld_data = 8'hBE;
    mem_valid = 1'b1; mem_addr = 13'h010; mem_wstrb = 4'h0;
    t_ld = -1; t_mem = -1; both = 1'b0; first_ce = 'x; rdata = 'x;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (n == 0) first_ce = ram_ce;
      if (ld_ready && mem_ready) both = 1'b1;
      if (ld_ready && t_ld < 0) begin t_ld = n; ld_valid = 1'b0; end
      if (mem_ready && t_mem < 0) begin t_mem = n; rdata = mem_rdata; mem_valid = 1'b0; break; end
    end
    @(posedge clk); #1;
    check("arb_first_ce",  {28'b0, first_ce}, 32'h2);
    check("arb_ld_lat",    t_ld, 1);
    check("arb_mem_after", t_mem - t_ld, 4);
    check("arb_both_rdy",  {31'b0, both}, 32'h0);
    check("arb_rdata",     rdata, 32'h5AAABEEF);

    // Reset asserted while a read sits in RD_WAIT.
    mem_valid = 1'b1; mem_addr = 13'h010; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    check("mid_ce_active", {28'b0, ram_ce}, 32'hF);
    resetn = 1'b0;
    #1;
    check("mid_rst_ce",    {28'b0, ram_ce},  32'h0);
    check("mid_rst_ad",    {21'b0, ram_ad},  32'h0);
    check("mid_rst_rdata", mem_rdata,        32'h0);
    check("mid_rst_viol",  {31'b0, wr_viol}, 32'h0);
    mem_valid = 1'b0;
    both = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (mem_ready || ld_ready) both = 1'b1;
    end
    resetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (mem_ready || ld_ready) both = 1'b1;
    end
    check("mid_no_ready", {31'b0, both}, 32'h0);
    do_access(mk(0, 13'h010, 32'h0, 4'h0, 0, 4'hF, 4'h0, 11'h004, 2, 32'h5AAABEEF, 0),
              ce, wre, ad, din, ce_after, lat, rdata, other);
    check("post_rst_latency", lat, 2);
    check("post_rst_rdata",   rdata, 32'h5AAABEEF);
    check("post_rst_viol",    {31'b0, wr_viol}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
